// File: rtl/md5_key_gen.sv
// Candidate key enumerator for the MD5 pre-stage: a 64-byte message is built in INIT, then
// each RUN cycle overwrites one byte, walking the charset in reflected mixed-radix Gray order.
module md5_key_gen #(
   parameter int MAX_LEN = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [3:0]  len,
   input  logic [7:0]  cs_min,
   input  logic [7:0]  cs_max,
   output logic [5:0]  offset_out,
   output logic [7:0]  msbyte_out,
   output logic        cand_valid,
   output logic [39:0] cand_idx,
   output logic        busy,
   output logic        done,
   output logic        err
);
   localparam int SW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
   state_t state, state_nx;

   logic [3:0]              len_q;
   logic [7:0]              min_q, max_q;
   logic [5:0]              cnt;
   logic [MAX_LEN-1:0][7:0] dig;
   logic [MAX_LEN-1:0]      dir_dn, mov;
   logic [SW-1:0]           sel;
   logic                    any_mov, start_ok, step;
   logic [7:0]              step_val, init_val;
   logic [5:0]              off_nx;
   logic [7:0]              byte_nx;
   logic                    cv_nx, done_nx, err_nx;
   logic [39:0]             idx_nx;

   assign start_ok = (len != 4'd0) && (int'(len) <= MAX_LEN) && (cs_min <= cs_max);
   assign busy     = (state != IDLE);

   for (genvar j = 0; j < MAX_LEN; j++) begin : g_dig
      assign mov[j] = (j < int'(len_q)) && (dir_dn[j] ? (dig[j] > min_q) : (dig[j] < max_q));
   end

   // lowest-index movable digit wins
   always_comb begin
      sel = '0;
      for (int j = MAX_LEN - 1; j >= 0; j--)
         if (mov[j]) sel = SW'(j);
   end

   assign any_mov  = |mov;
   assign step_val = dir_dn[sel] ? dig[sel] - 8'd1 : dig[sel] + 8'd1;

   // message template: key bytes, 0x80 pad marker, bit length in byte 56
   always_comb begin
      if (cnt < {2'b00, len_q})       init_val = min_q;
      else if (cnt == {2'b00, len_q}) init_val = 8'h80;
      else if (cnt == 6'd56)          init_val = {1'b0, len_q, 3'b000};
      else                            init_val = 8'h00;
   end

   always_comb begin
      state_nx = state;
      off_nx   = offset_out;
      byte_nx  = msbyte_out;
      cv_nx    = 1'b0;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      idx_nx   = cand_idx;
      step     = 1'b0;
      case (state)
         IDLE: begin
            if (!abort && start) begin
               if (start_ok) begin
                  state_nx = INIT;
                  off_nx   = 6'd0;
                  byte_nx  = cs_min;
               end else begin
                  err_nx = 1'b1;
               end
            end
         end
         INIT: begin
            if (abort) begin
               state_nx = IDLE;
            end else begin
               off_nx  = cnt;
               byte_nx = init_val;
               if (cnt == 6'd63) begin
                  cv_nx    = 1'b1;
                  idx_nx   = '0;
                  state_nx = RUN;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_nx = IDLE;
            end else if (any_mov) begin
               step    = 1'b1;
               off_nx  = 6'(sel);
               byte_nx = step_val;
               cv_nx   = 1'b1;
               idx_nx  = cand_idx + 40'd1;
            end else begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         offset_out <= '0;
         msbyte_out <= '0;
         cand_valid <= 1'b0;
         cand_idx   <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         cnt        <= 6'd1;
         len_q      <= '0;
         min_q      <= '0;
         max_q      <= '0;
         dig        <= '0;
         dir_dn     <= '0;
      end else begin
         state      <= state_nx;
         offset_out <= off_nx;
         msbyte_out <= byte_nx;
         cand_valid <= cv_nx;
         cand_idx   <= idx_nx;
         done       <= done_nx;
         err        <= err_nx;
         // offset 0 is written on the accepting edge, so INIT continues from 1
         cnt        <= (state == INIT) ? cnt + 6'd1 : 6'd1;
         if (state == IDLE && state_nx == INIT) begin
            len_q  <= len;
            min_q  <= cs_min;
            max_q  <= cs_max;
            dir_dn <= '0;
            for (int j = 0; j < MAX_LEN; j++) dig[j] <= cs_min;
         end
         if (step) begin
            dig[sel] <= step_val;
            for (int j = 0; j < MAX_LEN; j++)
               if (j < int'(sel)) dir_dn[j] <= ~dir_dn[j];
         end
      end
   end
endmodule

// File: tb/tb_md5_key_gen.sv
// Bench for md5_key_gen: downstream message model, arithmetic Gray-code reference per index.
module tb_md5_key_gen;
   localparam int MAX_LEN = 8;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [3:0]  len = '0;
   logic [7:0]  cs_min = '0, cs_max = '0;
   logic [5:0]  offset_out;
   logic [7:0]  msbyte_out;
   logic        cand_valid, busy, done, err;
   logic [39:0] cand_idx;

   int errors = 0, checks = 0;
   logic [7:0] msg [64];
   bit seen [logic [255:0]];

   md5_key_gen #(.MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
      .cs_min(cs_min), .cs_max(cs_max), .offset_out(offset_out), .msbyte_out(msbyte_out),
      .cand_valid(cand_valid), .cand_idx(cand_idx), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Expected byte k of candidate n: digit i is reflected when floor(n / R^(i+1)) is odd.
   function automatic logic [7:0] model_byte(longint n, int k, int l, int mn, int r);
      longint p, d;
      if (k < l) begin
         p = 1;
         for (int i = 0; i < k; i++) p = p * r;
         d = (n / p) % r;
         if (((n / (p * r)) % 2) == 1) d = r - 1 - d;
         return 8'(mn + d);
      end
      if (k == l)  return 8'h80;
      if (k == 56) return 8'(l * 8);
      return 8'h00;
   endfunction

   task automatic run_enum(input int l, input int mn, input int mx, input bit poke);
      int r, total, n, cyc, k;
      bit fin, bad;
      logic [255:0] key;
      r = mx - mn + 1;
      total = 1;
      for (int i = 0; i < l; i++) total = total * r;
      seen.delete();
      len = 4'(l); cs_min = 8'(mn); cs_max = 8'(mx);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0; fin = 0;
      for (cyc = 1; cyc <= total + 70 && !fin; cyc++) begin
         @(negedge clk);
         if (poke && cyc == 10) begin start = 1'b1; len = 4'd0; end
         if (poke && cyc == 11) begin start = 1'b0; len = 4'(l); end
         if (poke && (cyc == 11 || cyc == 12)) begin
            checks++;
            if (err !== 1'b0) begin
               errors++;
               $display("FAIL start_while_busy cyc=%0d: err=%b want 0", cyc, err);
            end
         end
         if (cyc <= 64) begin
            k = cyc - 1;
            checks++;
            if (offset_out !== 6'(k) || msbyte_out !== model_byte(0, k, l, mn, r)) begin
               errors++;
               $display("FAIL init_write cyc=%0d: got (%0d,%h) want (%0d,%h)", cyc,
                        offset_out, msbyte_out, k, model_byte(0, k, l, mn, r));
            end
            checks++;
            if (cand_valid !== (cyc == 64)) begin
               errors++;
               $display("FAIL init_valid cyc=%0d: cand_valid=%b want %b", cyc, cand_valid, cyc == 64);
            end
         end
         msg[offset_out] = msbyte_out;
         if (cand_valid) begin
            checks++;
            if (cand_idx !== 40'(n)) begin
               errors++;
               $display("FAIL cand_idx: got %0d want %0d", cand_idx, n);
            end
            bad = 0;
            for (int i = 0; i < 64; i++)
               if (msg[i] !== model_byte(longint'(n), i, l, mn, r)) bad = 1;
            checks++;
            if (bad) begin
               errors++;
               $display("FAIL message idx=%0d: bytes0..3 %h %h %h %h want %h %h %h %h", n,
                        msg[0], msg[1], msg[2], msg[3],
                        model_byte(longint'(n), 0, l, mn, r), model_byte(longint'(n), 1, l, mn, r),
                        model_byte(longint'(n), 2, l, mn, r), model_byte(longint'(n), 3, l, mn, r));
            end
            key = '0;
            for (int i = 0; i < l; i++) key[i*8 +: 8] = msg[i];
            checks++;
            if (seen.exists(key)) begin
               errors++;
               $display("FAIL unique idx=%0d: key %h repeated, want new key", n, key[31:0]);
            end
            seen[key] = 1'b1;
            n++;
         end
         if (done) begin
            fin = 1;
            checks++;
            if (cyc != 64 + total || busy !== 1'b0 || cand_valid !== 1'b0) begin
               errors++;
               $display("FAIL done_timing: cyc=%0d busy=%b cv=%b want cyc=%0d busy=0 cv=0",
                        cyc, busy, cand_valid, 64 + total);
            end
         end
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL timeout: no done after %0d cycles, want done", total + 70);
      end
      checks++;
      if (n != total) begin
         errors++;
         $display("FAIL count: got %0d candidates want %0d", n, total);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({offset_out, msbyte_out, cand_valid, cand_idx, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: off=%0d byte=%h idx=%0d busy=%b want all 0",
                  offset_out, msbyte_out, cand_idx, busy);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({offset_out, msbyte_out, cand_valid, cand_idx, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: off=%0d byte=%h busy=%b want all 0",
                  offset_out, msbyte_out, busy);
      end
   endtask

   task automatic test_basic();
      run_enum(1, 8'h61, 8'h63, 1'b0);
   endtask

   task automatic test_gray_small();
      run_enum(2, 8'h30, 8'h31, 1'b1);
   endtask

   task automatic test_single_symbol();
      run_enum(2, 8'h41, 8'h41, 1'b0);
   endtask

   task automatic test_reject();
      int tl [3] = '{9, 4, 0};
      int tn [3] = '{8'h61, 8'h40, 8'h61};
      int tx [3] = '{8'h62, 8'h3F, 8'h62};
      logic [5:0] o; logic [7:0] b; logic [39:0] ix;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         o = offset_out; b = msbyte_out; ix = cand_idx;
         len = 4'(tl[t]); cs_min = 8'(tn[t]); cs_max = 8'(tx[t]);
         @(posedge clk); #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
         @(negedge clk);
         checks++;
         if (err !== 1'b1 || busy !== 1'b0 || offset_out !== o || msbyte_out !== b || cand_idx !== ix) begin
            errors++;
            $display("FAIL reject_%0d: err=%b busy=%b off=%0d byte=%h want err=1 busy=0 off=%0d byte=%h",
                     t, err, busy, offset_out, msbyte_out, o, b);
         end
         @(negedge clk);
         checks++;
         if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reject_pulse_%0d: err=%b busy=%b want 0 0", t, err, busy);
         end
      end
      len = 4'd2; cs_min = 8'h30; cs_max = 8'h31;
      @(posedge clk); #1 start = 1'b1; abort = 1'b1;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_start c=%0d: busy=%b err=%b want 0 0", c, busy, err);
         end
      end
   endtask

   task automatic test_abort();
      logic [5:0] o; logic [7:0] b; bit bad;
      len = 4'd3; cs_min = 8'h61; cs_max = 8'h7A;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (99) @(posedge clk);
      @(negedge clk);
      o = offset_out; b = msbyte_out;
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || cand_valid !== 1'b0 || offset_out !== o || msbyte_out !== b) begin
         errors++;
         $display("FAIL abort_run: busy=%b done=%b cv=%b off=%0d byte=%h want 0 0 0 %0d %h",
                  busy, done, cand_valid, offset_out, msbyte_out, o, b);
      end
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0 || offset_out !== o || msbyte_out !== b) bad = 1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL abort_hold: busy=%b done=%b off=%0d want idle holding off=%0d", busy, done, offset_out, o);
      end
      // abort raised during the cycle whose edge would otherwise finish the run
      len = 4'd1; cs_min = 8'h61; cs_max = 8'h62;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (64) @(posedge clk);
      @(negedge clk);
      checks++;
      if (cand_valid !== 1'b1 || cand_idx !== 40'd1) begin
         errors++;
         $display("FAIL last_cand: cv=%b idx=%0d want 1 1", cand_valid, cand_idx);
      end
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_priority: done=%b busy=%b want 0 0", done, busy);
      end
      run_enum(3, 8'h61, 8'h62, 1'b0);
   endtask

   task automatic test_reset_mid_run();
      bit bad;
      len = 4'd4; cs_min = 8'h30; cs_max = 8'h32;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (80) @(posedge clk);
      #2;
      checks++;
      if (busy !== 1'b1 || cand_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_run: busy=%b cv=%b want 1 1", busy, cand_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({offset_out, msbyte_out, cand_valid, cand_idx, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL async_reset: off=%0d byte=%h idx=%0d busy=%b want all 0",
                  offset_out, msbyte_out, cand_idx, busy);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || cand_valid !== 1'b0) bad = 1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL after_reset: done=%b busy=%b want idle with no done", done, busy);
      end
      run_enum(4, 8'h30, 8'h32, 1'b0);
   endtask

   task automatic test_random();
      int l, r, mn;
      for (int it = 0; it < 6; it++) begin
         l  = int'($urandom_range(1, 4));
         r  = int'($urandom_range(1, 4));
         mn = int'($urandom_range(0, 256 - r));
         run_enum(l, mn, mn + r - 1, it[0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gray_small();
      test_single_symbol();
      test_reject();
      test_abort();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/md5_key_gen.md
MD5_KEY_GEN -- requirements
Module: md5_key_gen

Interface
REQ-001 Parameter: MAX_LEN, default 8, maximum candidate length in bytes (1..31).
REQ-002 Port: clk  in  1  sole clock; all state on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: start  in  1  single-cycle request to begin enumeration; sampled only in IDLE.
REQ-005 Port: abort  in  1  stop enumeration; return to IDLE.
REQ-006 Port: len  in  4  candidate length in bytes, valid 1..MAX_LEN.
REQ-007 Port: cs_min  in  8  lowest charset byte, inclusive.
REQ-008 Port: cs_max  in  8  highest charset byte, inclusive.
REQ-009 Port: offset_out  out  6  byte offset to overwrite in the downstream 64-byte message (word = [5:2], byte = [1:0], little-endian).
REQ-010 Port: msbyte_out  out  8  byte value written at offset_out.
REQ-011 Port: cand_valid  out  1  the message held after this cycle's write is a complete candidate.
REQ-012 Port: cand_idx  out  40  sequence number of the candidate flagged by cand_valid, starting at 0.
REQ-013 Port: busy  out  1  high in INIT and RUN.
REQ-014 Port: done  out  1  one-cycle pulse when enumeration completes.
REQ-015 Port: err  out  1  one-cycle pulse when start is rejected.

Function
REQ-016 The block SHALL drive the byte-overwrite stream consumed by the MD5 pre-stage pipeline: exactly one (offset_out, msbyte_out) write per cycle; every write is applied downstream, so consecutive candidates differ in exactly one byte.
REQ-017 offset_out, msbyte_out, cand_valid, cand_idx, done and err SHALL be registered outputs.
REQ-018 FSM states SHALL be IDLE, INIT and RUN.
REQ-019 In IDLE, offset_out/msbyte_out SHALL hold their last values (an idempotent rewrite), cand_valid SHALL be 0 and busy SHALL be 0.
REQ-020 Start is rejected, err pulses the next cycle and the FSM stays in IDLE if len==0, len>MAX_LEN or cs_min>cs_max.
REQ-021 start while busy SHALL be ignored, with no err.
REQ-022 On an accepted start at cycle T, the FSM SHALL latch len, cs_min and cs_max, and enter INIT.
REQ-023 INIT SHALL emit offsets 0..63 in order on cycles T+1..T+64.
REQ-024 INIT byte values by offset k: k<len gives cs_min; k==len gives 0x80; k==56 gives len*8; all other offsets give 0x00.
REQ-025 cand_valid SHALL be 1 with cand_idx=0 on the offset-63 write (cycle T+64).
REQ-026 RUN SHALL enumerate digits 0..len-1 in reflected mixed-radix Gray order, with radix R=cs_max-cs_min+1.
REQ-027 Each digit SHALL have a direction bit, reset to up in INIT.
REQ-028 A digit is movable if its direction is up and its value is below cs_max, or its direction is down and its value is above cs_min.
REQ-029 Each RUN cycle SHALL select the lowest-index movable digit i, step it by +/-1, and toggle the direction of all digits j<i.
REQ-030 Each RUN cycle SHALL emit offset_out=i and msbyte_out=the new value, with cand_valid=1 and cand_idx incremented by 1.
REQ-031 When no digit is movable, the FSM SHALL leave RUN to IDLE, emit no write, and pulse done in that cycle with busy=0.
REQ-032 The total candidate count SHALL be R^len, and the last cand_idx SHALL be R^len-1.
REQ-033 If R==1, INIT SHALL produce the only candidate, and done SHALL pulse on the first RUN evaluation (cycle T+65).
REQ-034 cand_idx SHALL wrap modulo 2^40 without affecting enumeration.
REQ-035 abort in INIT or RUN SHALL return the FSM to IDLE on the next edge, with no done, cand_valid=0 and outputs holding.
REQ-036 abort SHALL take priority over a simultaneous final step.
REQ-037 abort and start in the same IDLE cycle: abort wins and start is ignored.

Reset
REQ-038 While rst_n=0, state SHALL be IDLE and every output SHALL be 0 (offset_out=0, msbyte_out=0, cand_idx=0, busy=0, done=0, err=0, cand_valid=0).
REQ-039 A reset asserted mid-INIT or mid-RUN SHALL discard all progress, and no done SHALL follow.
REQ-040 After reset release, the first accepted start SHALL always replay the full 64-write INIT.

Verification
REQ-041 len=1, cs_min=0x61, cs_max=0x63, start at T -> 64 INIT writes (offset 0=0x61, offset 1=0x80, offset 56=0x08, others 0); cand_valid at T+64 idx 0; (0,0x62) idx 1 at T+65; (0,0x63) idx 2 at T+66; done at T+67.
REQ-042 len=2, cs 0x30..0x31 -> after INIT the RUN writes are (0,0x31),(1,0x31),(0,0x30); 4 candidates total; done follows; the downstream model shows messages "00","10","11","01".
REQ-043 len=9 with MAX_LEN=8, or cs_min=0x40 with cs_max=0x3F -> err pulse, busy stays 0, outputs unchanged.
REQ-044 len=3, cs 0x61..0x7A, abort at cycle T+100 -> busy low at T+101, no done, outputs hold; a later start replays INIT from offset 0.
REQ-045 rst_n pulled low mid-RUN, len=4 -> all outputs 0 immediately; a scoreboard checks that every cand_valid message is unique and that the count equals R^len for a full random run (R<=4, len<=4).
